// File: rtl/console_out.sv
// console_out: CPU-side character output port.
//   The CPU pushes 16-bit words. Only the 7-bit ASCII field is kept, in a small
//   FIFO. A pacing FSM pops one character at a time and presents it on an
//   8-bit terminal port: bit 7 is the strobe and bits 6:0 carry the character.
//   A registered status word reports overflow, activity and the fill level.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   in_en   write strobe; one push per cycle
//   in      write data; only in[6:0] is stored
//   out_en  status read strobe; samples status and clears overflow
//   status  {overflow, active, 6'b0, count[7:0]}
//   busy    terminal not ready; only looked at while idle
//   out     {strobe, char}
module console_out #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int HOLD   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [15:0] in,
    input  logic        out_en,
    output logic [15:0] status,
    input  logic        busy,
    output logic [7:0]  out
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD - 1);
    localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    state_t                      state;
    logic [DEPTH-1:0][6:0]       mem;
    logic [ADDR_W-1:0]           wr_ptr;
    logic [ADDR_W-1:0]           rd_ptr;
    logic [ADDR_W:0]             count;
    logic [HW-1:0]               hold_cnt;
    logic                        overflow;

    logic full;
    logic push;
    logic pop;
    logic ovf_set;

    // Upper write bits are ignored by design.
    logic unused_in;
    assign unused_in = &{1'b0, in[15:7]};

    // Fullness is judged on the pre-edge count, so a write while full is
    // dropped even if the FSM pops on the same edge.
    assign full    = (count == CNT_FULL);
    assign push    = in_en && !full;
    assign ovf_set = in_en && full;
    assign pop     = (state == IDLE) && (count != '0) && !busy;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in[6:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            status   <= '0;
            state    <= IDLE;
            hold_cnt <= '0;
            out      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A read reports and clears overflow; a fresh overflow on the
            // same edge wins.
            if (out_en)
                status <= {overflow, (state != IDLE), 6'b0, 8'(count)};
            if (ovf_set)
                overflow <= 1'b1;
            else if (out_en)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        out      <= {1'b1, mem[rd_ptr]};
                        hold_cnt <= HOLD_INIT;
                        state    <= STROBE;
                    end else begin
                        out <= '0;
                    end
                end
                STROBE: begin
                    if (hold_cnt == '0) begin
                        out   <= '0;
                        state <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                GAP: begin
                    // Guarantees a low cycle before the next pop can happen.
                    out   <= '0;
                    state <= IDLE;
                end
                default: begin
                    out   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_console_out.sv
module tb_console_out;

    localparam int DEPTH = 8;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_en = 1'b0;
    logic [15:0] din = '0;
    logic        out_en = 1'b0;
    logic        busy = 1'b0;
    logic [15:0] status;
    logic [7:0]  dout;

    console_out #(.DEPTH(DEPTH), .ADDR_W(3), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in(din), .out_en(out_en),
        .status(status), .busy(busy), .out(dout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a character queue plus timing by edge index.
    // A pop at edge p shows the character on edges p..p+HOLD-1 and the port
    // can accept the next pop no earlier than edge p+HOLD+2.
    logic [6:0]  q[$];
    logic        m_ovf;
    logic [15:0] m_status;
    logic [6:0]  m_char;
    logic        m_have;
    int          t, ready_at, pop_t;

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_status = '0;
        m_have   = 1'b0;
        ready_at = t;
    endtask

    // Drive one cycle of inputs (called just after a falling edge), update
    // the model for the rising edge, then check outputs 1 time unit later.
    task automatic step(input logic e, input logic [15:0] d, input logic oe, input logic b);
        logic idle, pop, full;
        logic [7:0] exp_out;
        in_en = e; din = d; out_en = oe; busy = b;
        @(posedge clk);
        idle = (t >= ready_at);
        full = (q.size() == DEPTH);
        pop  = idle && (q.size() != 0) && !b;
        if (oe) m_status = {m_ovf, ~idle, 6'b0, 8'(q.size())};
        if (e && full) m_ovf = 1'b1;
        else if (oe)   m_ovf = 1'b0;
        if (pop) begin
            m_char   = q.pop_front();
            m_have   = 1'b1;
            pop_t    = t;
            ready_at = t + HOLD + 2;
        end
        if (e && !full) q.push_back(d[6:0]);
        exp_out = (m_have && (t - pop_t) < HOLD) ? {1'b1, m_char} : 8'h00;
        t++;
        #1;
        chk("out", {8'h00, dout}, {8'h00, exp_out});
        chk("status", status, m_status);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, b);
    endtask

    initial begin
        t = 0;
        pop_t = 0;
        m_char = '0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_out", {8'h00, dout}, 16'h0000);
        chk("rst_status", status, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Single character with junk upper bits.
        step(1'b1, 16'hFF41, 1'b0, 1'b0);
        idle_cycles(6, 1'b0);

        // Burst to full while busy, then one overflowing write.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0041 + 16'(i), 1'b0, 1'b1);
        step(1'b1, 16'h005A, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("st_ovf", status, 16'h8008);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("st_clr", status, 16'h0008);

        // Drain in order; then the queue is empty and idle.
        idle_cycles(40, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("st_empty", status, 16'h0000);

        // busy raised mid-strobe of 'A' with 'B' queued.
        step(1'b1, 16'h0041, 1'b0, 1'b0);
        step(1'b1, 16'h0042, 1'b0, 1'b0);
        idle_cycles(8, 1'b1);
        idle_cycles(8, 1'b0);

        // Write while full on the same edge the FSM pops.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0030 + 16'(i), 1'b0, 1'b1);
        step(1'b1, 16'h0063, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("st_fullpop", status, 16'hC007);
        idle_cycles(40, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Character 0 is a normal character.
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        idle_cycles(6, 1'b0);

        // Asynchronous reset mid-strobe with entries queued.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_out", {8'h00, dout}, 16'h0000);
        chk("arst_status", status, 16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(3, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("arst_read", status, 16'h0000);
        idle_cycles(6, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 40, 16'($urandom),
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30);
        end
        idle_cycles(50, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
